// File: rtl/mem_bus_ctrl.sv
// Memory subsystem behind a req/ack bus: RAM, six writable vector bytes at the top of the
// address space, programmable wait states and CPU RDY. Optional write watchpoint: MEM_WATCH_EN.
module mem_bus_ctrl #(
  parameter int                    ADDR_W   = 16,
  parameter int                    DATA_W   = 8,
  parameter int                    RAM_AW   = 15,
  parameter int                    WAIT_CYC = 1,
  parameter logic [2*DATA_W-1:0]   NMI_VEC  = 16'h0000,
  parameter logic [2*DATA_W-1:0]   RST_VEC  = 16'h2857,
  parameter logic [2*DATA_W-1:0]   IRQ_VEC  = 16'h0000,
  parameter logic [DATA_W-1:0]     OPEN_BUS = 8'hFF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              err,
  output logic              rdy,
`ifdef MEM_WATCH_EN
  input  logic [ADDR_W-1:0] watch_addr,
  output logic              watch_hit,
  output logic [DATA_W-1:0] watch_data,
`endif
  output logic [1:0]        o_dbg_state
);

  // Bus handshake: req is sampled only while rdy=1 (IDLE); the request is then owned by the
  // controller until the single-cycle ack, in whose cycle a new req may already be sampled.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] VEC_BASE = {ADDR_W{1'b1}} - ADDR_W'(5);

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_rw;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_ack;
  logic                r_err;
  logic                r_rdy;
  logic [DATA_W-1:0]   r_vec [0:5];
  logic [DATA_W-1:0]   r_mem [0:(2**RAM_AW)-1];

  logic                w_is_ram;
  logic                w_is_vec;
  logic [2:0]          w_vec_idx;
  logic [ADDR_W-1:0]   w_vec_off;
  logic [RAM_AW-1:0]   w_ram_idx;

  assign w_is_ram   = (r_addr >> RAM_AW) == '0;
  assign w_is_vec   = r_addr >= VEC_BASE;
  assign w_vec_off  = r_addr - VEC_BASE;
  assign w_vec_idx  = w_vec_off[2:0];
  assign w_ram_idx  = r_addr[RAM_AW-1:0];

  assign rdata       = r_rdata;
  assign ack         = r_ack;
  assign err         = r_err;
  assign rdy         = r_rdy;
  assign o_dbg_state = r_state;

`ifdef MEM_WATCH_EN
  logic                r_watch_hit;
  logic [DATA_W-1:0]   r_watch_data;
  assign watch_hit  = r_watch_hit;
  assign watch_data = r_watch_data;
`endif

  // RAM contents survive reset; a clr pulls the FSM out of ACCESS before the edge, so an
  // aborted write never reaches this block.
  always_ff @(posedge clk) begin
    if (r_state == S_ACCESS && !r_rw && w_is_ram)
      r_mem[w_ram_idx] <= r_wdata;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_rw     <= 1'b1;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_rdy    <= 1'b1;
      r_vec[0] <= NMI_VEC[DATA_W-1:0];
      r_vec[1] <= NMI_VEC[2*DATA_W-1:DATA_W];
      r_vec[2] <= RST_VEC[DATA_W-1:0];
      r_vec[3] <= RST_VEC[2*DATA_W-1:DATA_W];
      r_vec[4] <= IRQ_VEC[DATA_W-1:0];
      r_vec[5] <= IRQ_VEC[2*DATA_W-1:DATA_W];
`ifdef MEM_WATCH_EN
      r_watch_hit  <= 1'b0;
      r_watch_data <= '0;
`endif
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
`ifdef MEM_WATCH_EN
      r_watch_hit <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_addr  <= addr;
            r_rw    <= rw;
            r_wdata <= wdata;
            r_rdy   <= 1'b0;
            if (WAIT_CYC > 0) begin
              r_state <= S_WAIT;
              r_cnt   <= 4'(WAIT_CYC - 1);
            end else begin
              r_state <= S_ACCESS;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) r_state <= S_ACCESS;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        S_ACCESS: begin
          r_ack   <= 1'b1;
          r_rdy   <= 1'b1;
          r_state <= S_IDLE;
          if (w_is_ram) begin
            if (r_rw) r_rdata <= r_mem[w_ram_idx];
          end else if (w_is_vec) begin
            if (r_rw) r_rdata          <= r_vec[w_vec_idx];
            else      r_vec[w_vec_idx] <= r_wdata;
          end else begin
            r_err <= 1'b1;
            if (r_rw) r_rdata <= OPEN_BUS;
          end
`ifdef MEM_WATCH_EN
          if (!r_rw && r_addr == watch_addr) begin
            r_watch_hit  <= 1'b1;
            r_watch_data <= r_wdata;
          end
`endif
        end
        default: begin
          r_state <= S_IDLE;
          r_rdy   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: one instance with one wait state, one with none, both checked against
// an address-map model (associative array) under directed and random accesses.
module tb_mem_bus_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr;
  logic req1, rw1, ack1, err1, rdy1;
  logic [15:0] addr1;
  logic [7:0]  wdata1, rdata1;
  logic [1:0]  st1;
  logic req0, rw0, ack0, err0, rdy0;
  logic [15:0] addr0;
  logic [7:0]  wdata0, rdata0;
  logic [1:0]  st0;
`ifdef MEM_WATCH_EN
  logic [15:0] waddr1, waddr0;
  logic        hit1, hit0;
  logic [7:0]  wd1, wd0;
`endif

  mem_bus_ctrl #(.WAIT_CYC(1)) u_dut1 (
    .clk(clk), .clr(clr), .req(req1), .rw(rw1), .addr(addr1), .wdata(wdata1),
    .rdata(rdata1), .ack(ack1), .err(err1), .rdy(rdy1),
`ifdef MEM_WATCH_EN
    .watch_addr(waddr1), .watch_hit(hit1), .watch_data(wd1),
`endif
    .o_dbg_state(st1)
  );

  mem_bus_ctrl #(.WAIT_CYC(0)) u_dut0 (
    .clk(clk), .clr(clr), .req(req0), .rw(rw0), .addr(addr0), .wdata(wdata0),
    .rdata(rdata0), .ack(ack0), .err(err0), .rdy(rdy0),
`ifdef MEM_WATCH_EN
    .watch_addr(waddr0), .watch_hit(hit0), .watch_data(wd0),
`endif
    .o_dbg_state(st0)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: plain byte map per instance, keyed by the full address.
  logic [7:0] mdl1 [int];
  logic [7:0] mdl0 [int];
  logic [7:0] last1, last0;
  logic [7:0] wdm1, wdm0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 0 = RAM (below 32K), 1 = vector byte (top six addresses), 2 = unmapped
  function automatic int region(input logic [15:0] a);
    if (int'(a) < 32768) return 0;
    if (int'(a) >= 65536 - 6) return 1;
    return 2;
  endfunction

  task automatic reset_model();
    logic [7:0] v [6];
    v = '{8'h00, 8'h00, 8'h57, 8'h28, 8'h00, 8'h00};
    for (int i = 0; i < 6; i++) begin
      mdl1[65530 + i] = v[i];
      mdl0[65530 + i] = v[i];
    end
    last1 = 8'h00; last0 = 8'h00;
    wdm1  = 8'h00; wdm0  = 8'h00;
  endtask

  // Called just after a rising edge; leaves just after the edge that raised ack.
  task automatic access(input bit w0, input bit r, input logic [15:0] a,
                        input logic [7:0] d, input bit hold);
    int lat, lat_exp, reg_n;
    bit got, a_now, r_now;
    logic [7:0] exp_rd;
    reg_n   = region(a);
    lat_exp = w0 ? 2 : 3;
    if (r) exp_rd = (reg_n == 2) ? 8'hFF : (w0 ? mdl0[int'(a)] : mdl1[int'(a)]);
    else   exp_rd = w0 ? last0 : last1;
    if (w0) begin req0 = 1'b1; rw0 = r; addr0 = a; wdata0 = d; end
    else    begin req1 = 1'b1; rw1 = r; addr1 = a; wdata1 = d; end
    lat = 0; got = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        if (hold) begin
          if (w0) begin rw0 = ~r; addr0 = a ^ 16'h00FF; wdata0 = ~d; end
          else    begin rw1 = ~r; addr1 = a ^ 16'h00FF; wdata1 = ~d; end
        end else begin
          if (w0) req0 = 1'b0; else req1 = 1'b0;
        end
      end
      a_now = w0 ? ack0 : ack1;
      r_now = w0 ? rdy0 : rdy1;
      if (a_now) got = 1'b1;
      else chk("rdy_busy", {31'b0, r_now}, 32'd0);
    end
    if (w0) req0 = 1'b0; else req1 = 1'b0;
    chk("ack_seen", {31'b0, got}, 32'd1);
    chk("latency", lat, lat_exp);
    chk("err", {31'b0, (w0 ? err0 : err1)}, {31'b0, (reg_n == 2)});
    chk("rdy_at_ack", {31'b0, (w0 ? rdy0 : rdy1)}, 32'd1);
    chk(r ? "rdata_read" : "rdata_hold", {24'b0, (w0 ? rdata0 : rdata1)}, {24'b0, exp_rd});
`ifdef MEM_WATCH_EN
    begin
      bit exp_hit;
      exp_hit = !r && (a == (w0 ? waddr0 : waddr1));
      if (exp_hit) begin
        if (w0) wdm0 = d; else wdm1 = d;
      end
      chk("watch_hit", {31'b0, (w0 ? hit0 : hit1)}, {31'b0, exp_hit});
      chk("watch_data", {24'b0, (w0 ? wd0 : wd1)}, {24'b0, (w0 ? wdm0 : wdm1)});
    end
`endif
    if (r) begin
      if (w0) last0 = exp_rd; else last1 = exp_rd;
    end else if (reg_n != 2) begin
      if (w0) mdl0[int'(a)] = d; else mdl1[int'(a)] = d;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] pool [12];
    logic [15:0] ram_pool [5];
    int acks, idx;
    pool     = '{16'h0000, 16'h0010, 16'h0020, 16'h1234, 16'h7FFF, 16'hFFFA,
                 16'hFFFB, 16'hFFFC, 16'hFFFF, 16'h8000, 16'h9000, 16'hFFF9};
    ram_pool = '{16'h0000, 16'h0010, 16'h0020, 16'h1234, 16'h7FFF};
    clr = 1'b1;
    req1 = 1'b0; rw1 = 1'b1; addr1 = '0; wdata1 = '0;
    req0 = 1'b0; rw0 = 1'b1; addr0 = '0; wdata0 = '0;
`ifdef MEM_WATCH_EN
    waddr1 = 16'h0000; waddr0 = 16'hFFFE;
`endif
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy1", {31'b0, rdy1}, 32'd1);
    chk("rst_ack1", {31'b0, ack1}, 32'd0);
    chk("rst_err1", {31'b0, err1}, 32'd0);
    chk("rst_rdata1", {24'b0, rdata1}, 32'd0);
    chk("rst_rdy0", {31'b0, rdy0}, 32'd1);
    chk("rst_rdata0", {24'b0, rdata0}, 32'd0);
    #2 clr = 1'b0;
    @(posedge clk); #1;

    access(1'b0, 1'b1, 16'hFFFC, 8'h00, 1'b0);
    access(1'b0, 1'b1, 16'hFFFD, 8'h00, 1'b0);
    access(1'b0, 1'b0, 16'h0010, 8'hA5, 1'b0);
    access(1'b0, 1'b1, 16'h0010, 8'h00, 1'b0);
    access(1'b0, 1'b1, 16'h9000, 8'h00, 1'b0);
    access(1'b0, 1'b0, 16'h9000, 8'h5A, 1'b0);
    access(1'b0, 1'b1, 16'h9000, 8'h00, 1'b0);
    access(1'b0, 1'b1, 16'h8000, 8'h00, 1'b0);
    access(1'b0, 1'b1, 16'hFFF9, 8'h00, 1'b0);
    foreach (ram_pool[i]) begin
      access(1'b0, 1'b0, ram_pool[i], 8'(8'h70 + i), 1'b0);
      access(1'b1, 1'b0, ram_pool[i], 8'(8'h30 + i), 1'b0);
    end
    access(1'b0, 1'b1, 16'h7FFF, 8'h00, 1'b0);
    access(1'b0, 1'b0, 16'hFFFC, 8'h00, 1'b0);
    access(1'b0, 1'b1, 16'hFFFC, 8'h00, 1'b0);

    // Abort a write in its wait state: no ack, no RAM update, vectors back to reset values.
    req1 = 1'b1; rw1 = 1'b0; addr1 = 16'h0020; wdata1 = 8'h11;
    @(posedge clk); #1;
    req1 = 1'b0;
    #2 clr = 1'b1;
    #2 clr = 1'b0;
    reset_model();
    chk("abort_rdy", {31'b0, rdy1}, 32'd1);
    chk("abort_rdata", {24'b0, rdata1}, 32'd0);
    acks = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (ack1) acks++;
    end
    chk("abort_no_ack", acks, 0);
    access(1'b0, 1'b1, 16'hFFFC, 8'h00, 1'b0);
    access(1'b0, 1'b1, 16'h0020, 8'h00, 1'b0);

    // Zero-wait instance, req held through the ack cycle: one access every two cycles.
    access(1'b1, 1'b0, 16'h0000, 8'h5A, 1'b1);
    access(1'b1, 1'b0, 16'h0001, 8'hC3, 1'b1);
    access(1'b1, 1'b1, 16'h0000, 8'h00, 1'b1);
    access(1'b1, 1'b1, 16'h0001, 8'h00, 1'b1);

    for (int n = 0; n < 60; n++) begin
      idx = $urandom_range(0, 11);
      access(1'b0, 1'($urandom_range(0, 1)), pool[idx], 8'($urandom), 1'($urandom_range(0, 1)));
    end
    for (int n = 0; n < 30; n++) begin
      idx = $urandom_range(0, 11);
      access(1'b1, 1'($urandom_range(0, 1)), pool[idx], 8'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
